// File: rtl/sum_window_accumulator.sv
// Sums WINDOW consecutive unsigned samples and presents the total with a sticky overflow flag.
// Define ACC_SATURATE_EN to clamp the total at all-ones on overflow; otherwise it wraps.
module sum_window_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int WINDOW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_overflow,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam int         SUM_W      = ACC_WIDTH + 1;
  localparam logic [7:0] LAST_COUNT = 8'(WINDOW - 1);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [7:0]           count;
  logic                 sticky;
  logic                 carry;
  logic [SUM_W-1:0]     sum_ext;

  assign in_ready = (state == ACCUM);
  assign sum_ext  = {1'b0, acc} + SUM_W'(in_data);
  assign carry    = sum_ext[ACC_WIDTH];

  // Once saturated, acc is all-ones, so any further nonzero sample carries again and stays clamped.
  always_comb begin
    acc_next = sum_ext[ACC_WIDTH-1:0];
`ifdef ACC_SATURATE_EN
    if (carry) acc_next = '1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      count        <= '0;
      sticky       <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_valid    <= 1'b0;
    end else if (clear) begin
      // Abort wins over accepts and pending results; out_data keeps its last value.
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc    <= acc_next;
            sticky <= sticky | carry;
            count  <= count + 8'd1;
            if (count == LAST_COUNT) begin
              out_data     <= acc_next;
              out_overflow <= sticky | carry;
              out_valid    <= 1'b1;
              state        <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            sticky    <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
